// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// Port 0 is the CPU, port 1 the loader/debug port; read data returns two cycles after grant.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_LOCK   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} owner_t;

    owner_t          owner, owner_nxt;
    logic            prio, prio_nxt;
    logic [LW-1:0]   lcnt, lcnt_nxt;

    logic            win_valid;
    logic            win_port;
    logic            accept;
    logic            sel_we;
    logic            sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic            tag_v;
    logic            tag_p;

    // An owner that stops requesting falls back to the free-running rules in the same cycle.
    always_comb begin
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (owner == OWN0 && req0) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (owner == OWN1 && req1) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end else if (req0 && req1) begin
            win_valid = 1'b1;
            win_port  = prio;
        end else if (req0) begin
            win_valid = 1'b1;
            win_port  = 1'b0;
        end else if (req1) begin
            win_valid = 1'b1;
            win_port  = 1'b1;
        end
    end

    assign gnt0   = rst_n && win_valid && !win_port;
    assign gnt1   = rst_n && win_valid && win_port;
    assign accept = gnt0 || gnt1;

    assign sel_we   = win_port ? we1    : we0;
    assign sel_lock = win_port ? lock1  : lock0;
    assign sel_addr = win_port ? addr1  : addr0;
    assign sel_data = win_port ? wdata1 : wdata0;

    always_comb begin
        owner_nxt = FREE;
        lcnt_nxt  = '0;
        prio_nxt  = prio;
        if (accept) begin
            prio_nxt = ~win_port;
            if (sel_lock && (int'(lcnt) + 1 < MAX_LOCK)) begin
                owner_nxt = win_port ? OWN1 : OWN0;
                lcnt_nxt  = lcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= FREE;
            prio  <= 1'b0;
            lcnt  <= '0;
        end else begin
            owner <= owner_nxt;
            prio  <= prio_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    // Memory-side registers plus the two-stage read tag; rvalid* form the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            tag_v    <= 1'b0;
            tag_p    <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            mem_we <= accept && sel_we;
            if (accept) begin
                mem_addr <= sel_addr;
                mem_data <= sel_data;
            end
            tag_v   <= accept && !sel_we;
            tag_p   <= win_port;
            rvalid0 <= tag_v && !tag_p;
            rvalid1 <= tag_v && tag_p;
        end
    end

    assign rdata = mem_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port synchronous data memory between the CPU (port 0) and the program loader / debug port (port 1). Accepts at most one access per cycle, with round-robin fairness and a bounded lock so the CPU can fetch a two-word instruction back-to-back. Memory-side signals are registered. Read data is routed back to the issuing port with a fixed 2-cycle latency.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 6, memory address width
- MAX_LOCK, 2, maximum consecutive grants one port may hold via `lock` (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read (qualified by req)
- lock0 / lock1  in  1  request priority for the next cycle as well
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  combinational; access accepted this cycle when req&gnt
- rvalid0 / rvalid1  out  1  registered; read data valid for that port
- rdata  out  DATA_WIDTH  read data, equals mem_q, meaningful only with an rvalid
- mem_we  out  1  registered memory write enable
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_data  out  DATA_WIDTH  registered memory write data
- mem_q  in  DATA_WIDTH  memory read data, valid the cycle after mem_addr is presented for a read

## Operation
- State: `owner` ∈ {FREE, OWN0, OWN1}, round-robin pointer `prio` (port with priority when FREE), lock counter `lcnt` (0..MAX_LOCK).
- Winner per cycle:
  - OWN*i* with req*i*=1 → *i*.
  - OWN*i* with req*i*=0 → fall back to FREE rules this cycle.
  - FREE → sole requester wins; if both request, `prio` wins.
- gnt*i* = req*i* & (winner==*i*); at most one gnt high; never high while rst_n=0.
- On an accepted access by port *i*:
  - `prio` ← other port.
  - If lock*i*=1 and lcnt+1 < MAX_LOCK: owner ← OWN*i*, lcnt ← lcnt+1.
  - Otherwise owner ← FREE, lcnt ← 0. The lock limit is reached, so rotation is forced.
- No access accepted → owner ← FREE, lcnt ← 0, `prio` unchanged.
- Accepted access is latched at the edge: mem_addr ← addr, mem_data ← wdata, mem_we ← we (1-cycle pulse). Read additionally sets a 2-stage tag pipeline {valid, port}.
- Idle cycle: mem_we ← 0; mem_addr/mem_data hold last value.
- rvalid*i* asserted exactly in the cycle the tag pipeline delivers port *i*; rdata = mem_q (passthrough).

## Timing
- Reset values:
  - mem_we=0, mem_addr=0, mem_data=0.
  - rvalid0=rvalid1=0, tag pipeline cleared.
  - owner=FREE, prio=port 0, lcnt=0.
- Accept in cycle T:
  - Memory sees the access in T+1.
  - A write commits at the end of T+1.
  - Read data appears with rvalid in T+2.
- Throughput 1 access/cycle. Reads and writes interleave freely; rvalid pulses keep issue order.
- Write in T then read of the same address in T+1 returns the new value (T+3).
- Request dropped without grant: no effect, no state change.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid after reset release.
  - A pending mem_we is cleared immediately (async).
- MAX_LOCK=1: lock has no effect; pure round-robin.

## Test plan
- Reset: hold rst_n=0 with both reqs high → gnt0=gnt1=0, mem_we=0, mem_addr=0. Release → port 0 granted first (prio reset).
- Single read: preload mem[5]=16'h1234; port 0 read addr 5 in T → gnt0 in T, mem_addr=5 in T+1, rvalid0=1 and rdata=16'h1234 in T+2, rvalid1=0 throughout.
- Contention: both ports request reads continuously for 6 cycles, no lock → grants alternate 0,1,0,1,0,1. rvalid pattern is the same sequence delayed by 2 cycles.
- Lock: MAX_LOCK=2, port 0 reads addr 10,11 with lock0=1 while port 1 requests → gnt0 in T and T+1, gnt1 in T+2. With lock0 held for 3 accesses, port 1 still wins the third cycle.
- Write/read hazard: port 1 writes 16'hBEEF to addr 63 in T, port 0 reads addr 63 in T+1 → mem_we=1 only in T+1, rvalid0 with rdata=16'hBEEF in T+3.
- Reset mid-read: accept port 1 read in T, assert rst_n=0 in T+1 for one cycle → no rvalid1 ever appears. Owner is FREE and prio is port 0 after release.
